// File: rtl/batch_issuer.sv
// Purpose: drains one built SBR by walking SBR -> SRR chain -> request chain and
//          issuing each request to the DRAM command generator, then invalidates the SBR.
// Ports:   start/sbr_id/busy/done/error/issued_count control, three synchronous
//          table read ports (sbr_rd_*, srr_rd_*, req_rd_*), iss_* valid/ready issue
//          port, sbr_clr_* invalidate pulse.
// Latency: first issue 3*RD_LAT cycles after start, RD_LAT per request within an
//          SRR, 2*RD_LAT when crossing to the next SRR.
// Backpressure: iss_valid and all iss_* fields hold until iss_ready; traversal
//          stalls in ISSUE while the downstream is not ready.
module batch_issuer #(
    parameter int REQ_W  = 8,
    parameter int SRR_W  = 6,
    parameter int SBR_W  = 4,
    parameter int ROW_W  = 16,
    parameter int BG_W   = 2,
    parameter int BK_W   = 2,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SBR_W-1:0] sbr_id,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [REQ_W-1:0] issued_count,
    output logic [SBR_W-1:0] sbr_rd_addr,
    input  logic [SRR_W-1:0] sbr_rd_head_srr,
    input  logic [SRR_W-1:0] sbr_rd_row_count,
    input  logic [REQ_W-1:0] sbr_rd_total_requests,
    input  logic [BG_W-1:0]  sbr_rd_bank_group,
    input  logic [BK_W-1:0]  sbr_rd_bank,
    output logic [SRR_W-1:0] srr_rd_addr,
    input  logic [REQ_W-1:0] srr_rd_head_req,
    input  logic [REQ_W-1:0] srr_rd_count,
    input  logic [SRR_W-1:0] srr_rd_next_srr,
    output logic [REQ_W-1:0] req_rd_addr,
    input  logic [REQ_W-1:0] req_rd_next_req,
    input  logic [ROW_W-1:0] req_rd_row,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [REQ_W-1:0] iss_req_id,
    output logic [ROW_W-1:0] iss_row,
    output logic [BG_W-1:0]  iss_bank_group,
    output logic [BK_W-1:0]  iss_bank,
    output logic             iss_row_first,
    output logic             iss_last,
    output logic             sbr_clr_en,
    output logic [SBR_W-1:0] sbr_clr_addr
);

    typedef enum logic [2:0] {
        IDLE, RD_SBR, RD_SRR, RD_REQ, ISSUE, CLEAR, DONE
    } state_t;

    // Wait counter terminal value: data is sampled on the RD_LAT-th edge
    // after the address register was loaded.
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_t           state_q, state_d;
    logic [2:0]       wait_q, wait_d;
    logic [SBR_W-1:0] sbr_addr_q, sbr_addr_d;
    logic [SRR_W-1:0] srr_addr_q, srr_addr_d;
    logic [REQ_W-1:0] req_addr_q, req_addr_d;
    logic [SRR_W-1:0] rows_left_q, rows_left_d;
    logic [REQ_W-1:0] reqs_left_q, reqs_left_d;
    logic [REQ_W-1:0] total_q, total_d;
    logic [BG_W-1:0]  bg_q, bg_d;
    logic [BK_W-1:0]  bk_q, bk_d;
    logic [SRR_W-1:0] srr_next_q, srr_next_d;
    logic [REQ_W-1:0] req_next_q, req_next_d;
    logic             row_first_q, row_first_d;
    logic [REQ_W-1:0] issued_q, issued_d;
    logic             error_q, error_d;
    logic             iss_valid_q, iss_valid_d;
    logic [REQ_W-1:0] iss_req_id_q, iss_req_id_d;
    logic [ROW_W-1:0] iss_row_q, iss_row_d;
    logic [BG_W-1:0]  iss_bg_q, iss_bg_d;
    logic [BK_W-1:0]  iss_bk_q, iss_bk_d;
    logic             iss_row_first_q, iss_row_first_d;
    logic             iss_last_q, iss_last_d;

    logic             rd_hit;
    logic [SRR_W-1:0] rows_dec;

    assign rd_hit   = (wait_q == LAT_M1);
    assign rows_dec = rows_left_q - SRR_W'(1);

    always_comb begin
        state_d         = state_q;
        wait_d          = 3'd0;
        sbr_addr_d      = sbr_addr_q;
        srr_addr_d      = srr_addr_q;
        req_addr_d      = req_addr_q;
        rows_left_d     = rows_left_q;
        reqs_left_d     = reqs_left_q;
        total_d         = total_q;
        bg_d            = bg_q;
        bk_d            = bk_q;
        srr_next_d      = srr_next_q;
        req_next_d      = req_next_q;
        row_first_d     = row_first_q;
        issued_d        = issued_q;
        error_d         = error_q;
        iss_valid_d     = iss_valid_q;
        iss_req_id_d    = iss_req_id_q;
        iss_row_d       = iss_row_q;
        iss_bg_d        = iss_bg_q;
        iss_bk_d        = iss_bk_q;
        iss_row_first_d = iss_row_first_q;
        iss_last_d      = iss_last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sbr_addr_d = sbr_id;
                    error_d    = 1'b0;
                    issued_d   = '0;
                    state_d    = RD_SBR;
                end
            end

            RD_SBR: begin
                if (!rd_hit) begin
                    wait_d = wait_q + 3'd1;
                end else begin
                    total_d = sbr_rd_total_requests;
                    bg_d    = sbr_rd_bank_group;
                    bk_d    = sbr_rd_bank;
                    if (sbr_rd_row_count == '0) begin
                        // Nothing was built here; leave the entry alone.
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        rows_left_d = sbr_rd_row_count;
                        srr_addr_d  = sbr_rd_head_srr;
                        state_d     = RD_SRR;
                    end
                end
            end

            RD_SRR: begin
                if (!rd_hit) begin
                    wait_d = wait_q + 3'd1;
                end else begin
                    srr_next_d = srr_rd_next_srr;
                    if (srr_rd_count == '0) begin
                        // Empty row: flag it and move straight to the next SRR,
                        // using the pointer just read rather than the stored one.
                        error_d     = 1'b1;
                        rows_left_d = rows_dec;
                        if (rows_dec != '0) begin
                            srr_addr_d = srr_rd_next_srr;
                            state_d    = RD_SRR;
                        end else begin
                            state_d = CLEAR;
                        end
                    end else begin
                        reqs_left_d = srr_rd_count;
                        req_addr_d  = srr_rd_head_req;
                        row_first_d = 1'b1;
                        state_d     = RD_REQ;
                    end
                end
            end

            RD_REQ: begin
                if (!rd_hit) begin
                    wait_d = wait_q + 3'd1;
                end else begin
                    req_next_d      = req_rd_next_req;
                    iss_req_id_d    = req_addr_q;
                    iss_row_d       = req_rd_row;
                    iss_bg_d        = bg_q;
                    iss_bk_d        = bk_q;
                    iss_row_first_d = row_first_q;
                    iss_last_d      = (reqs_left_q == REQ_W'(1)) &&
                                      (rows_left_q == SRR_W'(1));
                    iss_valid_d     = 1'b1;
                    state_d         = ISSUE;
                end
            end

            ISSUE: begin
                if (iss_ready) begin
                    issued_d    = issued_q + REQ_W'(1);
                    reqs_left_d = reqs_left_q - REQ_W'(1);
                    row_first_d = 1'b0;
                    iss_valid_d = 1'b0;
                    if (reqs_left_q != REQ_W'(1)) begin
                        req_addr_d = req_next_q;
                        state_d    = RD_REQ;
                    end else begin
                        // Last request of this SRR: the tail's next pointer is
                        // never followed, traversal length comes from counts only.
                        rows_left_d = rows_dec;
                        if (rows_dec != '0) begin
                            srr_addr_d = srr_next_q;
                            state_d    = RD_SRR;
                        end else begin
                            state_d = CLEAR;
                        end
                    end
                end
            end

            CLEAR: begin
                if (issued_q != total_q) begin
                    error_d = 1'b1;
                end
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            wait_q          <= 3'd0;
            sbr_addr_q      <= '0;
            srr_addr_q      <= '0;
            req_addr_q      <= '0;
            rows_left_q     <= '0;
            reqs_left_q     <= '0;
            total_q         <= '0;
            bg_q            <= '0;
            bk_q            <= '0;
            srr_next_q      <= '0;
            req_next_q      <= '0;
            row_first_q     <= 1'b0;
            issued_q        <= '0;
            error_q         <= 1'b0;
            iss_valid_q     <= 1'b0;
            iss_req_id_q    <= '0;
            iss_row_q       <= '0;
            iss_bg_q        <= '0;
            iss_bk_q        <= '0;
            iss_row_first_q <= 1'b0;
            iss_last_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            sbr_addr_q      <= sbr_addr_d;
            srr_addr_q      <= srr_addr_d;
            req_addr_q      <= req_addr_d;
            rows_left_q     <= rows_left_d;
            reqs_left_q     <= reqs_left_d;
            total_q         <= total_d;
            bg_q            <= bg_d;
            bk_q            <= bk_d;
            srr_next_q      <= srr_next_d;
            req_next_q      <= req_next_d;
            row_first_q     <= row_first_d;
            issued_q        <= issued_d;
            error_q         <= error_d;
            iss_valid_q     <= iss_valid_d;
            iss_req_id_q    <= iss_req_id_d;
            iss_row_q       <= iss_row_d;
            iss_bg_q        <= iss_bg_d;
            iss_bk_q        <= iss_bk_d;
            iss_row_first_q <= iss_row_first_d;
            iss_last_q      <= iss_last_d;
        end
    end

    // busy drops on the edge entering DONE, the same edge that raises done.
    assign busy           = (state_q != IDLE) && (state_q != DONE);
    assign done           = (state_q == DONE);
    assign error          = error_q;
    assign issued_count   = issued_q;
    assign sbr_rd_addr    = sbr_addr_q;
    assign srr_rd_addr    = srr_addr_q;
    assign req_rd_addr    = req_addr_q;
    assign iss_valid      = iss_valid_q;
    assign iss_req_id     = iss_req_id_q;
    assign iss_row        = iss_row_q;
    assign iss_bank_group = iss_bg_q;
    assign iss_bank       = iss_bk_q;
    assign iss_row_first  = iss_row_first_q;
    assign iss_last       = iss_last_q;
    assign sbr_clr_en     = (state_q == CLEAR);
    assign sbr_clr_addr   = sbr_addr_q;

endmodule

// File: tb/tb_batch_issuer.sv
// Directed bench for batch_issuer with RD_LAT=2: table contents are loaded by
// hand, each scenario task drives a drain and compares against hand-computed
// issue order, timing, clear and done/error results.
module tb_batch_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  sbr_id;
    logic        busy, done, error;
    logic [7:0]  issued_count;
    logic [3:0]  sbr_rd_addr;
    logic [5:0]  sbr_rd_head_srr, sbr_rd_row_count;
    logic [7:0]  sbr_rd_total_requests;
    logic [1:0]  sbr_rd_bank_group, sbr_rd_bank;
    logic [5:0]  srr_rd_addr;
    logic [7:0]  srr_rd_head_req, srr_rd_count;
    logic [5:0]  srr_rd_next_srr;
    logic [7:0]  req_rd_addr, req_rd_next_req;
    logic [15:0] req_rd_row;
    logic        iss_valid, iss_ready;
    logic [7:0]  iss_req_id;
    logic [15:0] iss_row;
    logic [1:0]  iss_bank_group, iss_bank;
    logic        iss_row_first, iss_last;
    logic        sbr_clr_en;
    logic [3:0]  sbr_clr_addr;

    batch_issuer #(.RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sbr_id(sbr_id),
        .busy(busy), .done(done), .error(error), .issued_count(issued_count),
        .sbr_rd_addr(sbr_rd_addr), .sbr_rd_head_srr(sbr_rd_head_srr),
        .sbr_rd_row_count(sbr_rd_row_count), .sbr_rd_total_requests(sbr_rd_total_requests),
        .sbr_rd_bank_group(sbr_rd_bank_group), .sbr_rd_bank(sbr_rd_bank),
        .srr_rd_addr(srr_rd_addr), .srr_rd_head_req(srr_rd_head_req),
        .srr_rd_count(srr_rd_count), .srr_rd_next_srr(srr_rd_next_srr),
        .req_rd_addr(req_rd_addr), .req_rd_next_req(req_rd_next_req), .req_rd_row(req_rd_row),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_req_id(iss_req_id),
        .iss_row(iss_row), .iss_bank_group(iss_bank_group), .iss_bank(iss_bank),
        .iss_row_first(iss_row_first), .iss_last(iss_last),
        .sbr_clr_en(sbr_clr_en), .sbr_clr_addr(sbr_clr_addr)
    );

    always #5 clk = ~clk;

    // Table contents
    logic [5:0]  sbr_head_m [16];
    logic [5:0]  sbr_rows_m [16];
    logic [7:0]  sbr_total_m[16];
    logic [1:0]  sbr_bg_m   [16];
    logic [1:0]  sbr_bk_m   [16];
    logic [7:0]  srr_head_m [64];
    logic [7:0]  srr_cnt_m  [64];
    logic [5:0]  srr_next_m [64];
    logic [7:0]  req_next_m [256];
    logic [15:0] req_row_m  [256];

    // One register stage here plus the DUT's sampling edge gives a 2-cycle read.
    always @(posedge clk) begin
        sbr_rd_head_srr       <= sbr_head_m[sbr_rd_addr];
        sbr_rd_row_count      <= sbr_rows_m[sbr_rd_addr];
        sbr_rd_total_requests <= sbr_total_m[sbr_rd_addr];
        sbr_rd_bank_group     <= sbr_bg_m[sbr_rd_addr];
        sbr_rd_bank           <= sbr_bk_m[sbr_rd_addr];
        srr_rd_head_req       <= srr_head_m[srr_rd_addr];
        srr_rd_count          <= srr_cnt_m[srr_rd_addr];
        srr_rd_next_srr       <= srr_next_m[srr_rd_addr];
        req_rd_next_req       <= req_next_m[req_rd_addr];
        req_rd_row            <= req_row_m[req_rd_addr];
    end

    // Monitor: sampled on the falling edge, recording handshakes, clears, dones.
    int          nidx = 0;
    logic [7:0]  got_id[$];
    logic [15:0] got_row[$];
    logic [1:0]  got_bg[$], got_bk[$];
    logic        got_first[$], got_last[$];
    int          hs_n[$];
    int          clr_cnt = 0, clr_n = 0, done_cnt = 0, done_n = 0;
    logic [3:0]  clr_addr = '0;
    logic        done_err = 1'b0;
    logic [7:0]  done_icnt = '0;

    always @(negedge clk) begin
        nidx++;
        if (iss_valid && iss_ready) begin
            got_id.push_back(iss_req_id);
            got_row.push_back(iss_row);
            got_bg.push_back(iss_bank_group);
            got_bk.push_back(iss_bank);
            got_first.push_back(iss_row_first);
            got_last.push_back(iss_last);
            hs_n.push_back(nidx);
        end
        if (sbr_clr_en) begin
            clr_cnt++;
            clr_addr = sbr_clr_addr;
            clr_n    = nidx;
        end
        if (done) begin
            done_cnt++;
            done_err  = error;
            done_icnt = issued_count;
            done_n    = nidx;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Returns one tick after the edge that samples start.
    task automatic start_drain(input logic [3:0] id);
        @(posedge clk); #1;
        start  = 1'b1;
        sbr_id = id;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Runs until done is seen; k counts edges after the start-sampling edge.
    task automatic run_until_done(input int budget, output int first_k, output int done_k);
        first_k = -1;
        done_k  = -1;
        for (int k = 1; k <= budget && done_k < 0; k++) begin
            @(posedge clk); #1;
            if (iss_valid && first_k < 0) first_k = k;
            if (done) done_k = k;
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sbr_id = '0; iss_ready = 1'b0;
        #3;
        n_cmp++;
        if ({busy, done, error, iss_valid, sbr_clr_en, iss_row_first, iss_last} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {busy, done, error, iss_valid, sbr_clr_en, iss_row_first, iss_last});
        end
        n_cmp++;
        if ({issued_count, iss_req_id, iss_row} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {issued_count, iss_req_id, iss_row});
        end
        n_cmp++;
        if ({sbr_rd_addr, srr_rd_addr, req_rd_addr, sbr_clr_addr} !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_addr: got %h want 0",
                     {sbr_rd_addr, srr_rd_addr, req_rd_addr, sbr_clr_addr});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        int first_k, done_k, h0, c0;
        h0 = got_id.size(); c0 = clr_cnt;
        iss_ready = 1'b1;
        start_drain(4'd3);
        run_until_done(60, first_k, done_k);
        n_cmp++;
        if (done_k < 0) begin n_bad++; $display("FAIL single_timeout: no done within 60 cycles"); end
        n_cmp++;
        if (first_k != 6) begin n_bad++; $display("FAIL single_latency: got %0d want 6", first_k); end
        n_cmp++;
        if (got_id.size() - h0 != 1) begin
            n_bad++; $display("FAIL single_nissued: got %0d want 1", got_id.size() - h0);
        end else begin
            n_cmp++;
            if ({got_id[h0], got_first[h0], got_last[h0]} !== {8'd5, 1'b1, 1'b1}) begin
                n_bad++;
                $display("FAIL single_req: got id %0d first %b last %b want 5 1 1",
                         got_id[h0], got_first[h0], got_last[h0]);
            end
            n_cmp++;
            if ({got_row[h0], got_bg[h0], got_bk[h0]} !== {16'h1234, 2'd2, 2'd1}) begin
                n_bad++;
                $display("FAIL single_fields: got row %h bg %0d bk %0d want 1234 2 1",
                         got_row[h0], got_bg[h0], got_bk[h0]);
            end
        end
        n_cmp++;
        if (clr_cnt - c0 != 1 || clr_addr !== 4'd3) begin
            n_bad++; $display("FAIL single_clear: got %0d pulses addr %0d want 1 addr 3", clr_cnt - c0, clr_addr);
        end
        n_cmp++;
        if (done_n != clr_n + 1) begin
            n_bad++; $display("FAIL single_done_after_clr: got done %0d clr %0d want done=clr+1", done_n, clr_n);
        end
        n_cmp++;
        if ({done_err, done_icnt} !== {1'b0, 8'd1}) begin
            n_bad++; $display("FAIL single_status: got err %b cnt %0d want 0 1", done_err, done_icnt);
        end
    endtask

    task automatic test_two_srr();
        int first_k, done_k, h0;
        logic [7:0]  exp_id   [5] = '{8'd4, 8'd7, 8'd9, 8'd2, 8'd6};
        logic [15:0] exp_row  [5] = '{16'h0A04, 16'h0A07, 16'h0A09, 16'h0B02, 16'h0B06};
        logic        exp_first[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        exp_last [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          exp_gap  [4] = '{3, 3, 5, 3};
        h0 = got_id.size();
        iss_ready = 1'b1;
        start_drain(4'd5);
        run_until_done(100, first_k, done_k);
        n_cmp++;
        if (done_k < 0) begin n_bad++; $display("FAIL two_timeout: no done within 100 cycles"); end
        n_cmp++;
        if (got_id.size() - h0 != 5) begin
            n_bad++; $display("FAIL two_nissued: got %0d want 5", got_id.size() - h0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if ({got_id[h0+i], got_row[h0+i], got_first[h0+i], got_last[h0+i]} !==
                    {exp_id[i], exp_row[i], exp_first[i], exp_last[i]}) begin
                    n_bad++;
                    $display("FAIL two_req%0d: got id %0d row %h first %b last %b want %0d %h %b %b",
                             i, got_id[h0+i], got_row[h0+i], got_first[h0+i], got_last[h0+i],
                             exp_id[i], exp_row[i], exp_first[i], exp_last[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (hs_n[h0+i+1] - hs_n[h0+i] != exp_gap[i]) begin
                    n_bad++;
                    $display("FAIL two_gap%0d: got %0d want %0d", i, hs_n[h0+i+1] - hs_n[h0+i], exp_gap[i]);
                end
            end
        end
        n_cmp++;
        if ({done_err, done_icnt} !== {1'b0, 8'd5}) begin
            n_bad++; $display("FAIL two_status: got err %b cnt %0d want 0 5", done_err, done_icnt);
        end
    endtask

    task automatic test_stall();
        int stalled, done_k, h0, unstable;
        logic [29:0] snap;
        logic [7:0] exp_id[5] = '{8'd4, 8'd7, 8'd9, 8'd2, 8'd6};
        h0 = got_id.size();
        stalled = 0; unstable = 0; done_k = -1; snap = '0;
        iss_ready = 1'b1;
        start_drain(4'd5);
        for (int k = 1; k <= 150 && done_k < 0; k++) begin
            @(posedge clk); #1;
            if (iss_valid && iss_req_id == 8'd7 && stalled < 10) begin
                if (stalled == 0)
                    snap = {iss_req_id, iss_row, iss_bank_group, iss_bank, iss_row_first, iss_last};
                else if ({iss_req_id, iss_row, iss_bank_group, iss_bank, iss_row_first, iss_last} !== snap)
                    unstable++;
                iss_ready = 1'b0;
                stalled++;
            end else begin
                if (stalled > 0 && stalled < 10) unstable++;
                iss_ready = 1'b1;
            end
            if (done) done_k = k;
        end
        @(negedge clk); #1;
        n_cmp++;
        if (done_k < 0 || stalled != 10) begin
            n_bad++; $display("FAIL stall_run: got stalled %0d done_k %0d want 10 and done", stalled, done_k);
        end
        n_cmp++;
        if (unstable != 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", unstable); end
        n_cmp++;
        if (got_id.size() - h0 != 5) begin
            n_bad++; $display("FAIL stall_nissued: got %0d want 5", got_id.size() - h0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (got_id[h0+i] !== exp_id[i]) begin
                    n_bad++; $display("FAIL stall_order%0d: got %0d want %0d", i, got_id[h0+i], exp_id[i]);
                end
            end
        end
    endtask

    task automatic test_mismatch();
        int first_k, done_k, h0, c0;
        h0 = got_id.size(); c0 = clr_cnt;
        iss_ready = 1'b1;
        start_drain(4'd6);
        run_until_done(100, first_k, done_k);
        n_cmp++;
        if (done_k < 0) begin n_bad++; $display("FAIL mism_timeout: no done within 100 cycles"); end
        n_cmp++;
        if (got_id.size() - h0 != 5) begin
            n_bad++; $display("FAIL mism_nissued: got %0d want 5", got_id.size() - h0);
        end
        n_cmp++;
        if (clr_cnt - c0 != 1 || clr_addr !== 4'd6) begin
            n_bad++; $display("FAIL mism_clear: got %0d pulses addr %0d want 1 addr 6", clr_cnt - c0, clr_addr);
        end
        n_cmp++;
        if ({done_err, done_icnt} !== {1'b1, 8'd5}) begin
            n_bad++; $display("FAIL mism_status: got err %b cnt %0d want 1 5", done_err, done_icnt);
        end
    endtask

    task automatic test_empty();
        int done_k, h0, c0, d0, saw_vld;
        h0 = got_id.size(); c0 = clr_cnt; d0 = done_cnt;
        done_k = -1; saw_vld = 0;
        iss_ready = 1'b1;
        start_drain(4'd7);
        // Stray start while busy: must be ignored.
        start  = 1'b1;
        sbr_id = 4'd3;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (iss_valid) saw_vld++;
            if (done && done_k < 0) done_k = k;
        end
        @(negedge clk); #1;
        n_cmp++;
        if (done_k < 1 || done_k > 4) begin
            n_bad++; $display("FAIL empty_done_time: got %0d want 1..4", done_k);
        end
        n_cmp++;
        if (done_err !== 1'b1 || done_icnt !== 8'd0) begin
            n_bad++; $display("FAIL empty_status: got err %b cnt %0d want 1 0", done_err, done_icnt);
        end
        n_cmp++;
        if (saw_vld != 0 || got_id.size() != h0 || clr_cnt != c0) begin
            n_bad++; $display("FAIL empty_activity: got vld %0d clr %0d want 0 0", saw_vld, clr_cnt - c0);
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL empty_ignore_start: got dones %0d busy %b want 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int first_k, done_k, k0, c0, d0, h0;
        c0 = clr_cnt; d0 = done_cnt;
        iss_ready = 1'b0;
        start_drain(4'd5);
        k0 = -1;
        for (int k = 1; k <= 30 && k0 < 0; k++) begin
            @(posedge clk); #1;
            if (iss_valid) k0 = k;
        end
        n_cmp++;
        if (k0 < 0 || iss_req_id !== 8'd4) begin
            n_bad++; $display("FAIL rmid_valid: got k %0d id %0d want valid with id 4", k0, iss_req_id);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, iss_valid, sbr_clr_en, iss_row_first, iss_last} !== 6'b0 ||
            {iss_req_id, iss_row, sbr_rd_addr, srr_rd_addr, req_rd_addr} !== 42'h0) begin
            n_bad++;
            $display("FAIL rmid_async: got flags %b id %0d addrs %h want all 0",
                     {busy, done, iss_valid, sbr_clr_en, iss_row_first, iss_last}, iss_req_id,
                     {sbr_rd_addr, srr_rd_addr, req_rd_addr});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        iss_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (clr_cnt != c0 || done_cnt != d0) begin
            n_bad++; $display("FAIL rmid_no_finish: got clr %0d done %0d want 0 0", clr_cnt - c0, done_cnt - d0);
        end
        h0 = got_id.size();
        start_drain(4'd3);
        run_until_done(60, first_k, done_k);
        n_cmp++;
        if (done_k < 0 || got_id.size() - h0 != 1 || first_k != 6) begin
            n_bad++; $display("FAIL rmid_redrain: got done_k %0d n %0d first %0d want done 1 6",
                              done_k, got_id.size() - h0, first_k);
        end else begin
            n_cmp++;
            if (got_id[h0] !== 8'd5 || {done_err, done_icnt} !== {1'b0, 8'd1}) begin
                n_bad++; $display("FAIL rmid_result: got id %0d err %b cnt %0d want 5 0 1",
                                  got_id[h0], done_err, done_icnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            sbr_head_m[i] = '0; sbr_rows_m[i] = '0; sbr_total_m[i] = '0; sbr_bg_m[i] = '0; sbr_bk_m[i] = '0;
        end
        for (int i = 0; i < 64; i++) begin
            srr_head_m[i] = '0; srr_cnt_m[i] = '0; srr_next_m[i] = '0;
        end
        for (int i = 0; i < 256; i++) begin
            req_next_m[i] = '0; req_row_m[i] = '0;
        end
        // SBR 3: one SRR with one request (id 5); tail pointers lead nowhere useful.
        sbr_head_m[3] = 6'd10; sbr_rows_m[3] = 6'd1; sbr_total_m[3] = 8'd1;
        sbr_bg_m[3] = 2'd2; sbr_bk_m[3] = 2'd1;
        srr_head_m[10] = 8'd5; srr_cnt_m[10] = 8'd1; srr_next_m[10] = 6'd63;
        req_row_m[5] = 16'h1234; req_next_m[5] = 8'd99;
        // SBR 5: SRR 20 (4->7->9), SRR 21 (2->6); SBR 6 same chains, total off by one.
        sbr_head_m[5] = 6'd20; sbr_rows_m[5] = 6'd2; sbr_total_m[5] = 8'd5;
        sbr_bg_m[5] = 2'd1; sbr_bk_m[5] = 2'd3;
        sbr_head_m[6] = 6'd20; sbr_rows_m[6] = 6'd2; sbr_total_m[6] = 8'd6;
        srr_head_m[20] = 8'd4; srr_cnt_m[20] = 8'd3; srr_next_m[20] = 6'd21;
        srr_head_m[21] = 8'd2; srr_cnt_m[21] = 8'd2; srr_next_m[21] = 6'd0;
        req_next_m[4] = 8'd7; req_next_m[7] = 8'd9; req_next_m[9] = 8'd200;
        req_next_m[2] = 8'd6; req_next_m[6] = 8'd201;
        req_row_m[4] = 16'h0A04; req_row_m[7] = 16'h0A07; req_row_m[9] = 16'h0A09;
        req_row_m[2] = 16'h0B02; req_row_m[6] = 16'h0B06;
        // SBR 7: empty.
        sbr_head_m[7] = 6'd30; sbr_rows_m[7] = 6'd0; sbr_total_m[7] = 8'd0;

        test_reset();
        test_single();
        test_two_srr();
        test_stall();
        test_mismatch();
        test_empty();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
